mem_arbiter: RTL and testbench

Arbitrates the pipeline's instruction-fetch port and data-memory port onto a single SRAM-like bus with a req/addr_ok/data_ok handshake. It sits between the datapath (pcF/instrF, aluoutM/writedataM/sig_write/readdataM) and the memory interface. It latches one request at a time, drives the bus, returns read data and completion pulses, and generates stall signals for the hazard unit.

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester and bus signals of mem_arbiter.
// master: the arbiter's view (it masters the SRAM-like bus and serves
// the fetch/data requesters). slave: the environment's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch port
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_data_ok;
  logic              inst_stall;
  // data port
  logic              data_req;
  logic              data_wr;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_data_ok;
  logic              data_stall;
  // memory bus
  logic              bus_req;
  logic              bus_wr;
  logic [3:0]        bus_wstrb;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    input  inst_req, inst_addr,
    output inst_rdata, inst_data_ok, inst_stall,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_rdata, data_data_ok, data_stall,
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_rdata, inst_data_ok, inst_stall,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_rdata, data_data_ok, data_stall,
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM-like bus (req/addr_ok/data_ok) between the
// instruction-fetch port and the data-memory port, one transaction at a time.
// Optional macro ARB_ROUND_ROBIN_EN: on a tie the grant alternates using
// last_grant; without it the data port always wins a tie.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master mif
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              grant_q;          // 0 = inst, 1 = data
  logic              wr_q;
  logic [3:0]        wstrb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;
  logic              inst_ok_q, data_ok_q;

  logic req_any, sel_data, capture;

  assign req_any = mif.inst_req | mif.data_req;
  // response lands either together with the address handshake or later in WAIT
  assign capture = ((state_q == ADDR) & mif.bus_addr_ok & mif.bus_data_ok) |
                   ((state_q == WAIT) & mif.bus_data_ok);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  // tie goes to the port that did not win last time
  always_comb sel_data = (mif.inst_req & mif.data_req) ? ~last_grant_q : mif.data_req;

  // remember who was served, updated as the transaction enters RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         last_grant_q <= 1'b1;
    else if (capture) last_grant_q <= grant_q;
  end
`else
  // data wins ties so the MEM stage never waits behind a younger fetch
  always_comb sel_data = mif.data_req;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_any) state_d = ADDR;
      ADDR: if (mif.bus_addr_ok) state_d = mif.bus_data_ok ? RESP : WAIT;
      WAIT: if (mif.bus_data_ok) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs: bus_req decoded from state so it drops with async reset
  always_comb begin
    mif.bus_req      = (state_q == ADDR);
    mif.bus_wr       = wr_q;
    mif.bus_wstrb    = wstrb_q;
    mif.bus_addr     = addr_q;
    mif.bus_wdata    = wdata_q;
    mif.inst_rdata   = inst_rdata_q;
    mif.data_rdata   = data_rdata_q;
    mif.inst_data_ok = inst_ok_q;
    mif.data_data_ok = data_ok_q;
    mif.inst_stall   = mif.inst_req & ~inst_ok_q;
    mif.data_stall   = mif.data_req & ~data_ok_q;
  end

  // request latch in IDLE, response capture and one-cycle completion pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q      <= 1'b0;
      wr_q         <= 1'b0;
      wstrb_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
    end else begin
      inst_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      if ((state_q == IDLE) && req_any) begin
        grant_q <= sel_data;
        wr_q    <= sel_data & mif.data_wr;
        wstrb_q <= sel_data ? mif.data_wstrb : 4'b0000;
        addr_q  <= sel_data ? mif.data_addr  : mif.inst_addr;
        wdata_q <= sel_data ? mif.data_wdata : '0;
      end
      if (capture) begin
        if (grant_q) begin
          data_ok_q <= 1'b1;
          if (!wr_q) data_rdata_q <= mif.bus_rdata;
        end else begin
          inst_ok_q    <= 1'b1;
          inst_rdata_q <= mif.bus_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: drives both requesters and a bus responder with
// directed and random transactions; a transaction-level model predicts the
// grant, bus fields, latency and returned data.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .mif(mif));

  int checks = 0;
  int errors = 0;

  // reference state
  logic [31:0] inst_m, data_m;
  bit          last_m;   // 1 = data served last

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // arbitration rule: returns 1 when data is served
  function automatic bit pick(input bit ir, input bit dr);
    if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !last_m;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  // One transaction. Called at a negedge with requests set up so the
  // arbiter samples them in IDLE at the next edge. ad = cycles addr_ok is
  // withheld, same = addr_ok and data_ok together, dd = extra WAIT cycles.
  // Ends at the negedge of the IDLE cycle after RESP, winner's req dropped.
  task automatic txn(input int ad, input bit same, input int dd, input logic [31:0] rd);
    bit w;
    int n;
    logic [31:0] ea, ewd, sia, sda, swd;
    logic        ewr;
    logic [3:0]  es;
    w   = pick(mif.inst_req, mif.data_req);
    ea  = w ? mif.data_addr : mif.inst_addr;
    ewr = w ? mif.data_wr : 1'b0;
    es  = w ? mif.data_wstrb : 4'b0000;
    ewd = mif.data_wdata;
    @(negedge clk); n = 1;
    while (!mif.bus_req && n < 6) begin @(negedge clk); n++; end
    chk("req_latency", n, 1);
    chk("bus_addr", mif.bus_addr, ea);
    chk("bus_wr", {31'd0, mif.bus_wr}, {31'd0, ewr});
    chk("bus_wstrb", {28'd0, mif.bus_wstrb}, {28'd0, es});
    if (w) chk("bus_wdata", mif.bus_wdata, ewd);
    sia = mif.inst_addr; sda = mif.data_addr; swd = mif.data_wdata;
    repeat (ad) begin
      mif.inst_addr = $urandom; mif.data_addr = $urandom; mif.data_wdata = $urandom;
      mif.bus_data_ok = $urandom_range(0, 1);   // data_ok without addr_ok is ignored
      @(negedge clk); n++;
      chk("bp_bus_req", {31'd0, mif.bus_req}, 32'd1);
      chk("bp_bus_addr", mif.bus_addr, ea);
      chk("bp_ok", {30'd0, mif.inst_data_ok, mif.data_data_ok}, 32'd0);
    end
    mif.inst_addr = sia; mif.data_addr = sda; mif.data_wdata = swd;
    mif.bus_addr_ok = 1'b1; mif.bus_data_ok = same;
    mif.bus_rdata = same ? rd : $urandom;
    @(negedge clk); n++;
    mif.bus_addr_ok = 1'b0; mif.bus_data_ok = 1'b0;
    if (!same) begin
      chk("wait_bus_req", {31'd0, mif.bus_req}, 32'd0);
      repeat (dd) begin
        mif.bus_addr_ok = $urandom_range(0, 1);   // ignored outside ADDR
        @(negedge clk); n++;
        chk("wait_ok", {30'd0, mif.inst_data_ok, mif.data_data_ok}, 32'd0);
      end
      mif.bus_addr_ok = 1'b0; mif.bus_data_ok = 1'b1; mif.bus_rdata = rd;
      @(negedge clk); n++;
      mif.bus_data_ok = 1'b0;
    end
    chk("txn_cycles", n, same ? 2 + ad : 3 + ad + dd);
    if (!w) inst_m = rd;
    else if (!ewr) data_m = rd;
    last_m = w;
    chk("inst_data_ok", {31'd0, mif.inst_data_ok}, {31'd0, !w});
    chk("data_data_ok", {31'd0, mif.data_data_ok}, {31'd0, w});
    chk("inst_rdata", mif.inst_rdata, inst_m);
    chk("data_rdata", mif.data_rdata, data_m);
    chk("resp_stall", {31'd0, w ? mif.data_stall : mif.inst_stall}, 32'd0);
    if (w) mif.data_req = 1'b0; else mif.inst_req = 1'b0;
    @(negedge clk);
    chk("ok_pulse_width", {30'd0, mif.inst_data_ok, mif.data_data_ok}, 32'd0);
  endtask

  task automatic new_data(input bit wr);
    mif.data_req = 1'b1; mif.data_wr = wr; mif.data_wstrb = 4'($urandom);
    mif.data_addr = $urandom; mif.data_wdata = $urandom;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mif.inst_req = 0; mif.inst_addr = 0;
    mif.data_req = 0; mif.data_wr = 0; mif.data_wstrb = 0; mif.data_addr = 0; mif.data_wdata = 0;
    mif.bus_addr_ok = 0; mif.bus_data_ok = 0; mif.bus_rdata = 0;
    inst_m = 0; data_m = 0; last_m = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_bus_req", {31'd0, mif.bus_req}, 32'd0);
    chk("rst_bus_addr", mif.bus_addr, 32'd0);
    chk("rst_rdata", mif.inst_rdata | mif.data_rdata, 32'd0);
    chk("rst_ok", {30'd0, mif.inst_data_ok, mif.data_data_ok}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // fetch alone
    mif.inst_req = 1; mif.inst_addr = 32'hBFC00000;
    txn(1, 0, 1, 32'h3C1A0001);
    chk("t1_inst_rdata", mif.inst_rdata, 32'h3C1A0001);
    chk("t1_data_rdata", mif.data_rdata, 32'd0);

    // simultaneous requests: data store vs fetch
    mif.inst_req = 1; mif.inst_addr = $urandom;
    mif.data_req = 1; mif.data_wr = 1; mif.data_wstrb = 4'b0011;
    mif.data_addr = 32'h80001000; mif.data_wdata = 32'hDEADBEEF;
    txn(0, 0, 0, $urandom);
    txn(0, 0, 0, $urandom);

    // same-cycle handshake on a load
    new_data(1'b0);
    txn(0, 1, 0, $urandom);

    // address backpressure on a fetch with inputs churning
    mif.inst_req = 1; mif.inst_addr = $urandom;
    txn(10, 0, 1, $urandom);

    // continuous contention for four transactions
    mif.inst_req = 1; mif.inst_addr = $urandom;
    new_data($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) begin
      txn(0, 1'($urandom_range(0, 1)), 0, $urandom);
`ifndef ARB_ROUND_ROBIN_EN
      chk("contention_inst_stall", {31'd0, mif.inst_stall}, 32'd1);
`endif
      if (!mif.inst_req) begin mif.inst_req = 1; mif.inst_addr = $urandom; end
      if (!mif.data_req) new_data($urandom_range(0, 1));
    end
    // drain both pending requests
    txn(0, 0, 0, $urandom);
    txn(0, 0, 0, $urandom);

    // random traffic; a pending loser keeps its request until served
    for (int i = 0; i < 24; i++) begin
      if (!mif.inst_req && $urandom_range(0, 1)) begin mif.inst_req = 1; mif.inst_addr = $urandom; end
      if (!mif.data_req && $urandom_range(0, 1)) new_data($urandom_range(0, 1));
      if (!mif.inst_req && !mif.data_req) begin mif.inst_req = 1; mif.inst_addr = $urandom; end
      txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom);
    end
    if (mif.inst_req || mif.data_req) txn(0, 0, 0, $urandom);

    // reset while in WAIT
    mif.data_req = 1; mif.data_wr = 1; mif.data_wstrb = 4'hF;
    mif.data_addr = 32'h80000010; mif.data_wdata = $urandom;
    @(negedge clk);
    mif.bus_addr_ok = 1;
    @(negedge clk);
    mif.bus_addr_ok = 0;
    chk("pre_rst_wait", {31'd0, mif.bus_req}, 32'd0);
    #2 rst = 1'b0; mif.data_req = 0;
    #1;
    chk("mid_rst_bus_req", {31'd0, mif.bus_req}, 32'd0);
    chk("mid_rst_bus_addr", mif.bus_addr, 32'd0);
    chk("mid_rst_bus_ctl", {27'd0, mif.bus_wr, mif.bus_wstrb}, 32'd0);
    chk("mid_rst_inst_rdata", mif.inst_rdata, 32'd0);
    chk("mid_rst_data_rdata", mif.data_rdata, 32'd0);
    inst_m = 0; data_m = 0; last_m = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    // stale completion arriving in IDLE
    mif.bus_data_ok = 1; mif.bus_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    mif.bus_data_ok = 0;
    chk("stale_ok", {30'd0, mif.inst_data_ok, mif.data_data_ok}, 32'd0);
    chk("stale_bus_req", {31'd0, mif.bus_req}, 32'd0);
    chk("stale_rdata", mif.data_rdata, 32'd0);
    mif.data_req = 1; mif.data_wr = 0; mif.data_addr = 32'h80000004;
    txn(0, 0, 1, 32'h12345678);
    chk("post_rst_load", mif.data_rdata, 32'h12345678);

`ifdef ARB_ROUND_ROBIN_EN
    // after reset the first tie goes to the fetch
    mif.inst_req = 1; mif.inst_addr = 32'h00400000;
    new_data(1'b0);
    txn(0, 1, 0, $urandom);
    chk("rr_first_tie_inst", {31'd0, last_m}, 32'd0);
    txn(0, 1, 0, $urandom);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
